append_fcs_pad: RTL and testbench
=================================

// Module: append_fcs_pad
// PURPOSE
//  Parametrised Ethernet TX frame closer, successor of the fixed 64-bit CRC appender.
//  - Computes CRC-32 internally over the frame.
//  - Optionally zero-pads short frames to MIN_FRAME_BYTES; the CRC covers the pad bytes.
//  - Appends the 4-byte FCS, spilling into an extra beat when it does not fit.
//  Sits between the TX framer and the XGMII encoder.
// PARAMETERS
//  DATA_BYTES        8   bytes per beat; power of two, >= 4
//  DATA_BITS         DATA_BYTES*8  tdata width
//  PAD_ENABLE        1   1: pad frames shorter than MIN_FRAME_BYTES with 8'h00; 0: no padding
//  MIN_FRAME_BYTES   60  minimum payload+pad length, excluding FCS
//  ERR_INVERT_FCS    1   1: FCS XOR 32'hFFFFFFFF when input tuser=1 on tlast (forced bad FCS)
// PORTS
//  clock         in   1            clock
//  aresetn       in   1            reset, synchronous, active-low
//  saxis_tdata   in   DATA_BITS    frame data, byte 0 = LSB
//  saxis_tvalid  in   1            input valid
//  saxis_tready  out  1            input ready
//  saxis_tkeep   in   DATA_BYTES   contiguous from bit 0; all ones on non-last beats; may be 0 on tlast
//  saxis_tlast   in   1            last beat of frame
//  saxis_tuser   in   1            frame error flag, sampled on tlast beat
//  maxis_tdata   out  DATA_BITS    output data incl. pad and FCS
//  maxis_tvalid  out  1            output valid
//  maxis_tready  in   1            output ready
//  maxis_tkeep   out  DATA_BYTES   contiguous byte enables
//  maxis_tlast   out  1            last beat (always the beat holding the final FCS byte)
//  maxis_tuser   out  1            error flag, valid only with maxis_tlast
// BEHAVIOUR
//  Reset: all maxis_* = 0, saxis_tready = 0, state = DATA, byte_cnt = 0, crc = 32'hFFFFFFFF.
//  Output stage
//  - Single registered output stage.
//  - Latency 1 cycle from input handshake to maxis_tvalid.
//  - maxis_* hold stable while tvalid && !tready.
//  - Output register loads only when !maxis_tvalid || maxis_tready.
//  saxis_tready = (state==DATA) && (!maxis_tvalid || maxis_tready).
//  CRC
//  - Reflected CRC-32, poly 0x04C11DB7, init 32'hFFFFFFFF.
//  - Bytes processed LSB-first within each beat, only kept bytes.
//  - FCS = ~crc after the last payload/pad byte, transmitted low byte first.
//  - CRC and byte_cnt reset to init/0 when the FCS is issued.
//  byte_cnt: saturating at MIN_FRAME_BYTES, counts payload+pad bytes of the current frame.
//  Closing beat: the beat holding the final payload or pad byte; n = its byte count.
//  - n+4 <= DATA_BYTES: FCS at bytes n..n+3; keep = n+4 ones; tlast = 1; frame done.
//  - Otherwise: FCS low bytes fill n..DATA_BYTES-1; remaining FCS bytes go to a TAIL beat
//    (bytes 0.., keep = n+4-DATA_BYTES ones, tlast = 1); closing beat tlast = 0, tuser = 0.
//  States
//  - DATA: pass beats, crc/byte_cnt update. On tlast handshake, let total = byte_cnt + kept:
//    - PAD_ENABLE && total < MIN: zero-fill the rest of the beat, up to MIN.
//      If MIN is reached within the beat, it is the closing beat; otherwise emit a full
//      beat, latch the tuser flag and go PAD.
//    - Else: the input beat is the closing beat. Go TAIL if the FCS spills, else stay DATA.
//  - PAD: emit zero beats while (MIN - byte_cnt) > DATA_BYTES.
//    The final pad beat is the closing beat: TAIL if the FCS spills, else DATA.
//    Advances only when the output register loads.
//  - TAIL: emit the spill beat when the output register loads, then DATA.
//  - PAD and TAIL insert input back-pressure; no other bubbles.
//  Error flag
//  - tuser latched on the input tlast; driven on the output tlast beat.
//  - ERR_INVERT_FCS applies to all FCS bytes.
//  Boundary cases
//  - tlast with tkeep = 0: n = 0, FCS occupies bytes 0..3 of that beat.
//  - Frame exactly MIN bytes: no padding.
//  - Back-to-back frames: the next frame's first beat is accepted the cycle after the
//    previous closing/tail beat loads.
//  - Reset mid-frame or mid-PAD/TAIL: partial frame discarded, reset values restored next cycle.
// TESTING
//  T1
//  - Stimulus: PAD_ENABLE=0, DATA_BYTES=8, 9-byte frame "123456789" (2 beats, keep 8'hFF, 8'h01).
//  - Response: beat1 keep 8'h1F, bytes 8..12 = 39,26,39,F4,CB, tlast=1.
//  T2
//  - Stimulus: DATA_BYTES=8, 8-byte full beat with tlast, PAD_ENABLE=0.
//  - Response: FCS spills; out beat1 keep FF tlast=0, TAIL keep 0F tlast=1, saxis_tready low 1 cycle.
//  T3
//  - Stimulus: PAD_ENABLE=1, MIN=60, 14-byte frame.
//  - Response: 60 bytes (bytes 14..59 = 00) + FCS; 8 beats, last keep 8'hFF with FCS at bytes 4..7.
//    FCS equals software CRC of the padded 60 bytes.
//  T4
//  - Stimulus: tuser=1 on tlast, ERR_INVERT_FCS=1.
//  - Response: maxis_tuser=1 on tlast only; FCS = bitwise inverse of the T1 value (D9,C6,0B,34 for T1 data).
//  T5
//  - Stimulus: random maxis_tready (50%), back-to-back frames of 1..130 bytes, DATA_BYTES=4/8/16.
//  - Response: scoreboard matches padded payload+FCS per frame; maxis_* stable while stalled; no loss.
//  T6
//  - Stimulus: aresetn low for 1 cycle during PAD state.
//  - Response: next cycle all maxis_* = 0, saxis_tready = 0; then saxis_tready = 1 with
//    maxis_tvalid = 0 idle; the following frame gets a correct FCS.

Source files
------------

// File: rtl/append_fcs_pad.sv
// Ethernet TX frame closer: CRC-32 over payload (+ optional zero pad to a
// minimum length), FCS appended low byte first, spilling into a tail beat.
//
// Ports:
//   clock, aresetn       clock, synchronous active-low reset
//   saxis_t*             AXI-Stream input (tdata/tkeep/tlast/tuser/tvalid/tready)
//   maxis_t*             AXI-Stream output, single registered stage
module append_fcs_pad #(
    parameter int DATA_BYTES      = 8,
    parameter int DATA_BITS       = DATA_BYTES * 8,
    parameter bit PAD_ENABLE      = 1'b1,
    parameter int MIN_FRAME_BYTES = 60,
    parameter bit ERR_INVERT_FCS  = 1'b1
) (
    input  logic                  clock,
    input  logic                  aresetn,
    input  logic [DATA_BITS-1:0]  saxis_tdata,
    input  logic                  saxis_tvalid,
    output logic                  saxis_tready,
    input  logic [DATA_BYTES-1:0] saxis_tkeep,
    input  logic                  saxis_tlast,
    input  logic                  saxis_tuser,
    output logic [DATA_BITS-1:0]  maxis_tdata,
    output logic                  maxis_tvalid,
    input  logic                  maxis_tready,
    output logic [DATA_BYTES-1:0] maxis_tkeep,
    output logic                  maxis_tlast,
    output logic                  maxis_tuser
);
    localparam int CW = $clog2(MIN_FRAME_BYTES + 1);

    typedef enum logic [1:0] {S_DATA, S_PAD, S_TAIL} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           crc_q, crc_d;
    logic [31:0]           spill_q, spill_d;
    logic [2:0]            spill_n_q, spill_n_d;
    logic                  err_q, err_d;
    logic                  rdy_q;
    logic [DATA_BITS-1:0]  tdata_q, tdata_d;
    logic [DATA_BYTES-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;

    logic                  load;
    logic [DATA_BITS-1:0]  src, beat;
    logic [31:0]           crc_c, fcs;
    logic                  is_last, go, err_in, pad_now, closing;
    int                    kin, n, base;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [DATA_BYTES-1:0] ones(input int k);
        logic [DATA_BYTES-1:0] r;
        for (int i = 0; i < DATA_BYTES; i++)
            r[i] = (i < k);
        return r;
    endfunction

    // rdy_q holds tready low for the cycle right after reset
    assign load         = !tvalid_q || maxis_tready;
    assign saxis_tready = rdy_q && (state_q == S_DATA) && load;

    assign maxis_tdata  = tdata_q;
    assign maxis_tvalid = tvalid_q;
    assign maxis_tkeep  = tkeep_q;
    assign maxis_tlast  = tlast_q;
    assign maxis_tuser  = tuser_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        spill_d   = spill_q;
        spill_n_d = spill_n_q;
        err_d     = err_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        if (load)
            tvalid_d = 1'b0;

        kin = 0;
        for (int i = 0; i < DATA_BYTES; i++)
            if (saxis_tkeep[i])
                kin = kin + 1;
        src     = saxis_tdata;
        is_last = saxis_tlast;
        err_in  = saxis_tuser;
        go      = saxis_tvalid && saxis_tready;

        // A pad beat is handled as a last beat carrying no input bytes
        if (state_q == S_PAD) begin
            src     = '0;
            kin     = 0;
            is_last = 1'b1;
            err_in  = err_q;
            go      = load;
        end

        base    = int'(cnt_q);
        pad_now = PAD_ENABLE && is_last && (base + kin < MIN_FRAME_BYTES);
        closing = is_last;
        n       = kin;
        if (pad_now) begin
            closing = (base + DATA_BYTES >= MIN_FRAME_BYTES);
            n       = closing ? MIN_FRAME_BYTES - base : DATA_BYTES;
        end

        // Unkept input bytes become zeros, which double as pad bytes
        beat  = '0;
        crc_c = crc_q;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < kin)
                beat[8*i +: 8] = src[8*i +: 8];
            if (i < n)
                crc_c = crc_byte(crc_c, beat[8*i +: 8]);
        end
        fcs = ~crc_c;
        if (ERR_INVERT_FCS && err_in)
            fcs = ~fcs;
        if (closing)
            for (int i = 0; i < DATA_BYTES; i++)
                if (i >= n && i < n + 4)
                    beat[8*i +: 8] = fcs[8*(i-n) +: 8];

        if (state_q == S_TAIL) begin
            if (load) begin
                tvalid_d = 1'b1;
                tdata_d  = '0;
                for (int j = 0; j < 4; j++)
                    if (j < int'(spill_n_q))
                        tdata_d[8*j +: 8] = spill_q[8*j +: 8];
                tkeep_d  = ones(int'(spill_n_q));
                tlast_d  = 1'b1;
                tuser_d  = err_q;
                state_d  = S_DATA;
            end
        end else if (go) begin
            tvalid_d = 1'b1;
            tdata_d  = beat;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            if (closing) begin
                crc_d = '1;
                cnt_d = '0;
                if (n + 4 <= DATA_BYTES) begin
                    tkeep_d = ones(n + 4);
                    tlast_d = 1'b1;
                    tuser_d = err_in;
                    state_d = S_DATA;
                end else begin
                    // Keep only the FCS bytes that did not fit
                    tkeep_d   = '1;
                    spill_d   = fcs >> (8 * (DATA_BYTES - n));
                    spill_n_d = 3'(n + 4 - DATA_BYTES);
                    err_d     = err_in;
                    state_d   = S_TAIL;
                end
            end else begin
                tkeep_d = ones(n);
                crc_d   = crc_c;
                cnt_d   = (base + n >= MIN_FRAME_BYTES) ?
                          CW'(MIN_FRAME_BYTES) : CW'(base + n);
                if (pad_now) begin
                    err_d   = err_in;
                    state_d = S_PAD;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!aresetn) begin
            state_q   <= S_DATA;
            cnt_q     <= '0;
            crc_q     <= '1;
            spill_q   <= '0;
            spill_n_q <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            spill_q   <= spill_d;
            spill_n_q <= spill_n_d;
            err_q     <= err_d;
            rdy_q     <= 1'b1;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
        end
    end
endmodule

// File: tb/tb_append_fcs_pad.sv
// Bench for append_fcs_pad: random frames against a byte-queue model
// (pad to minimum, CRC-32, FCS append) with random output back-pressure.
module tb_append_fcs_pad;
    localparam int DB  = 8;
    localparam int MIN = 60;

    logic          clock = 1'b0;
    logic          aresetn;
    logic [DB*8-1:0] sdata;
    logic          svalid;
    logic          sready;
    logic [DB-1:0] skeep;
    logic          slast;
    logic          suser;
    logic [DB*8-1:0] mdata;
    logic          mvalid;
    logic          mready = 1'b1;
    logic [DB-1:0] mkeep;
    logic          mlast;
    logic          muser;

    int total = 0;
    int bad   = 0;
    bit mon_en  = 1'b0;
    bit rnd_rdy = 1'b0;

    byte unsigned exp_q[$];
    int           exp_len_q[$];
    bit           exp_err_q[$];
    byte unsigned got_q[$];

    always #5 clock = ~clock;

    append_fcs_pad #(
        .DATA_BYTES(DB), .DATA_BITS(DB*8), .PAD_ENABLE(1'b1),
        .MIN_FRAME_BYTES(MIN), .ERR_INVERT_FCS(1'b1)
    ) dut (
        .clock(clock), .aresetn(aresetn),
        .saxis_tdata(sdata), .saxis_tvalid(svalid), .saxis_tready(sready),
        .saxis_tkeep(skeep), .saxis_tlast(slast), .saxis_tuser(suser),
        .maxis_tdata(mdata), .maxis_tvalid(mvalid), .maxis_tready(mready),
        .maxis_tkeep(mkeep), .maxis_tlast(mlast), .maxis_tuser(muser)
    );

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DB-1:0] ones(input int k);
        logic [DB-1:0] r;
        for (int b = 0; b < DB; b++)
            r[b] = (b < k);
        return r;
    endfunction

    function automatic logic [31:0] crc32(input byte unsigned d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ 32'(d[i]);
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic expect_frame(input byte unsigned d[$], input bit err);
        byte unsigned p[$];
        logic [31:0]  f;
        p = d;
        while (p.size() < MIN)
            p.push_back(8'h00);
        f = crc32(p);
        if (err)
            f = ~f;
        for (int b = 0; b < 4; b++)
            p.push_back(f[8*b +: 8]);
        foreach (p[i])
            exp_q.push_back(p[i]);
        exp_len_q.push_back(p.size());
        exp_err_q.push_back(err);
    endtask

    task automatic send_frame(input byte unsigned d[$], input bit err,
                              input bit zl, input bit gaps, input bit record);
        int len;
        int idx;
        int k;
        int w;
        bit last;
        len = d.size();
        idx = 0;
        if (record)
            expect_frame(d, err);
        do begin
            k    = (len - idx > DB) ? DB : len - idx;
            last = (idx + k == len) && (k < DB || !zl);
            if (gaps && $urandom_range(0, 3) == 0) begin
                svalid = 1'b0;
                @(posedge clock);
                #1;
            end
            for (int b = 0; b < DB; b++)
                sdata[8*b +: 8] = (b < k) ? d[idx+b] : 8'($urandom);
            skeep  = ones(k);
            slast  = last;
            suser  = last ? err : 1'($urandom);
            svalid = 1'b1;
            w = 0;
            do begin
                @(negedge clock);
                w++;
            end while (!sready && w < 2000);
            if (!sready)
                check("sready_timeout", 96'(0), 96'(1));
            @(posedge clock);
            #1;
            svalid = 1'b0;
            idx    = idx + k;
        end while (!last);
    endtask

    task automatic take_beat();
        int k;
        int len;
        bit e;
        bit ok;
        byte unsigned x;
        k = 0;
        for (int b = 0; b < DB; b++)
            if (mkeep[b])
                k++;
        check("keep_contig", 96'(mkeep), 96'(ones(k)));
        for (int b = 0; b < k; b++)
            got_q.push_back(mdata[8*b +: 8]);
        if (!mlast) begin
            check("tuser_mid", 96'(muser), 96'(0));
        end else if (exp_len_q.size() == 0) begin
            check("extra_frame", 96'(got_q.size()), 96'(0));
            got_q.delete();
        end else begin
            len = exp_len_q.pop_front();
            e   = exp_err_q.pop_front();
            check("frame_len", 96'(got_q.size()), 96'(len));
            check("frame_err", 96'(muser), 96'(e));
            ok = 1'b1;
            for (int b = 0; b < len; b++) begin
                x = exp_q.pop_front();
                if (ok && b < got_q.size()) begin
                    check($sformatf("byte%0d", b), 96'(got_q[b]), 96'(x));
                    ok = (got_q[b] == x);
                end
            end
            got_q.delete();
        end
    endtask

    always @(posedge clock) begin
        #1;
        mready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [95:0] snap;
    bit          stalled = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (stalled)
                check("hold", 96'({mdata, mkeep, mlast, muser, mvalid}), snap);
            stalled = mvalid && !mready;
            snap    = 96'({mdata, mkeep, mlast, muser, mvalid});
            if (mvalid && mready)
                take_beat();
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        byte unsigned fr[$];
        int w;
        aresetn = 1'b0;
        svalid  = 1'b0;
        sdata   = '0;
        skeep   = '0;
        slast   = 1'b0;
        suser   = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out", 96'({mdata, mkeep, mlast, muser, mvalid, sready}), 96'(0));
        @(posedge clock);
        #1 aresetn = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_rdy", 96'({sready, mvalid}), 96'(2'b10));

        // Reset while padding a short frame
        fr.delete();
        for (int i = 0; i < 3; i++)
            fr.push_back(8'($urandom));
        send_frame(fr, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("in_pad", 96'(sready), 96'(0));
        aresetn = 1'b0;
        @(posedge clock);
        #1 aresetn = 1'b1;
        @(negedge clock);
        check("mid_rst", 96'({mdata, mkeep, mlast, muser, mvalid, sready}), 96'(0));
        @(negedge clock);
        check("post_rst", 96'({sready, mvalid}), 96'(2'b10));
        @(posedge clock);
        #1;

        mon_en  = 1'b1;
        rnd_rdy = 1'b1;

        fr.delete();
        for (int i = 0; i < 9; i++)
            fr.push_back(8'(8'h31 + i));
        send_frame(fr, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(fr, 1'b1, 1'b0, 1'b0, 1'b1);
        foreach (exp_len_q[i]) begin end
        for (int t = 0; t < 7; t++) begin
            fr.delete();
            for (int i = 0; i < (t == 0 ? 14 : t == 1 ? 60 : t == 2 ? 61 :
                                 t == 3 ? 64 : t == 4 ? 0 : t == 5 ? 8 : 128); i++)
                fr.push_back(8'($urandom));
            send_frame(fr, t[0], t == 3 || t == 6, 1'b0, 1'b1);
        end
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            w = $urandom_range(1, 130);
            for (int i = 0; i < w; i++)
                fr.push_back(8'($urandom));
            send_frame(fr, $urandom_range(0, 3) == 0, 1'($urandom),
                       1'b1, 1'b1);
        end

        w = 0;
        while (exp_len_q.size() != 0 && w < 5000) begin
            @(posedge clock);
            w++;
        end
        @(negedge clock);
        check("drain", 96'(exp_len_q.size()), 96'(0));
        check("leftover", 96'(got_q.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
